uart_rx_frame: RTL and testbench

- Parametrised UART receiver; successor to the board's RX-line activity detector.
- Synchronises UART_RXD, detects the start bit, samples each bit at mid-bit, and checks optional parity and 1 or 2 stop bits.
- Presents each received word with a one-cycle valid strobe and per-frame error flags.
- Retains a stretched line-activity output for the board LED.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync2.sv | 33 +++
 rtl/uart_rx_frame.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } rx_state_e;

    // Parity modes.
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Integer clocks per bit period; the remainder is deliberately dropped.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic INIT = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next-state for both stages.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchroniser flops; reset to the idle-line level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= INIT;
            sync_q <= INIT;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits, and a
// stretched line-activity indicator.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned BAUD      = 115_200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned ACT_HOLD  = 50_000_000
) (
    input  logic                 FPGA_CLK,
    input  logic                 FPGA_RST,
    input  logic                 UART_RXD,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    output logic                 RX_PARITY_ERR,
    output logic                 RX_FRAME_ERR,
    output logic                 RX_BUSY,
    output logic                 RX_ACTIVE
);

    localparam int unsigned CPB  = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned TW   = $clog2(CPB);
    localparam int unsigned IW   = $clog2(DATA_BITS);
    localparam int unsigned AW   = $clog2(ACT_HOLD + 1);

    logic rxd_s;

    rx_state_e state_d, state_q;

    logic [TW-1:0]        timer_d, timer_q;
    logic [IW-1:0]        idx_d, idx_q;
    logic [DATA_BITS-1:0] shift_d, shift_q;
    logic                 par_acc_d, par_acc_q;
    logic                 perr_d, perr_q;
    logic                 ferr_d, ferr_q;
    logic                 stop_d, stop_q;
    logic [DATA_BITS-1:0] data_d, data_q;
    logic                 valid_d, valid_q;
    logic                 oper_d, oper_q;
    logic                 oferr_d, oferr_q;
    logic [AW-1:0]        act_d, act_q;

    logic mid_start;
    logic bit_end;
    logic sample;
    logic last_bit;
    logic last_stop;

    uart_sync2 #(
        .INIT(1'b1)
    ) u_sync (
        .clk_i(FPGA_CLK),
        .rst_i(FPGA_RST),
        .d_i  (UART_RXD),
        .q_o  (rxd_s)
    );

    // Timing decodes shared by the FSM and the datapath.
    always_comb begin
        mid_start = (timer_q == TW'(HALF - 1));
        bit_end   = (timer_q == TW'(CPB - 1));
        sample    = bit_end &&
                    ((state_q == StData) || (state_q == StParity) || (state_q == StStop));
        last_bit  = (idx_q == IW'(DATA_BITS - 1));
        last_stop = (stop_q == 1'(STOP_BITS - 1));
    end

    // FSM state register.
    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!rxd_s) state_d = StStart;
            end
            StStart: begin
                // A line back high at mid start bit is treated as a glitch.
                if (mid_start) state_d = rxd_s ? StIdle : StData;
            end
            StData: begin
                if (bit_end && last_bit) begin
                    state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                end
            end
            StParity: begin
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                if (bit_end && last_stop) begin
                    state_d = (ferr_q || !rxd_s) ? StWaitHigh : StIdle;
                end
            end
            StWaitHigh: begin
                if (rxd_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        RX_BUSY       = (state_q != StIdle);
        RX_DATA       = data_q;
        RX_VALID      = valid_q;
        RX_PARITY_ERR = oper_q;
        RX_FRAME_ERR  = oferr_q;
        RX_ACTIVE     = (act_q != '0);
    end

    // Datapath next-state: bit timer, shift register, error accumulation, strobe.
    always_comb begin
        timer_d   = timer_q + 1'b1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_acc_d = par_acc_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        stop_d    = stop_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        oper_d    = oper_q;
        oferr_d   = oferr_q;

        // Timer restarts on every state entry and every sample taken.
        if ((state_q == StIdle) || (state_q == StWaitHigh) ||
            (state_d != state_q) || sample) begin
            timer_d = '0;
        end

        case (state_q)
            StIdle: begin
                // Clear per-frame state so the next frame starts clean.
                idx_d     = '0;
                par_acc_d = 1'b0;
                perr_d    = 1'b0;
                ferr_d    = 1'b0;
                stop_d    = 1'b0;
            end
            StData: begin
                if (sample) begin
                    shift_d[idx_q] = rxd_s;
                    par_acc_d      = par_acc_q ^ rxd_s;
                    idx_d          = last_bit ? '0 : idx_q + 1'b1;
                end
            end
            StParity: begin
                if (sample) begin
                    if (PARITY == PAR_ODD) begin
                        perr_d = ~(par_acc_q ^ rxd_s);
                    end else begin
                        perr_d = par_acc_q ^ rxd_s;
                    end
                end
            end
            StStop: begin
                if (sample) begin
                    ferr_d = ferr_q | ~rxd_s;
                    if (last_stop) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        oper_d  = (PARITY != PAR_NONE) && perr_q;
                        oferr_d = ferr_q | ~rxd_s;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Activity stretch: reload on any low sample, count down to zero otherwise.
    always_comb begin
        if (!rxd_s) begin
            act_d = AW'(ACT_HOLD);
        end else if (act_q != '0) begin
            act_d = act_q - 1'b1;
        end else begin
            act_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            timer_q   <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_acc_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            stop_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            oper_q    <= 1'b0;
            oferr_q   <= 1'b0;
            act_q     <= '0;
        end else begin
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_acc_q <= par_acc_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            stop_q    <= stop_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            oper_q    <= oper_d;
            oferr_q   <= oferr_d;
            act_q     <= act_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench: 8N1, 8E1 and 8N2 receivers at 10 clocks per bit.
module tb_uart_rx_frame;

    localparam int unsigned CPB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rxd = 3'b111;

    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       b0, b1, b2;
    logic       a0, a1, a2;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cnt0 = 0, cnt1 = 0, cnt2 = 0;
    int stamp0 = 0;
    logic [9:0] q0[$];

    always #5 clk = ~clk;

    uart_rx_frame #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
        .ACT_HOLD(50)
    ) u_n1 (
        .FPGA_CLK(clk), .FPGA_RST(rst), .UART_RXD(rxd[0]), .RX_DATA(d0), .RX_VALID(v0),
        .RX_PARITY_ERR(pe0), .RX_FRAME_ERR(fe0), .RX_BUSY(b0), .RX_ACTIVE(a0)
    );

    uart_rx_frame #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
        .ACT_HOLD(50)
    ) u_e1 (
        .FPGA_CLK(clk), .FPGA_RST(rst), .UART_RXD(rxd[1]), .RX_DATA(d1), .RX_VALID(v1),
        .RX_PARITY_ERR(pe1), .RX_FRAME_ERR(fe1), .RX_BUSY(b1), .RX_ACTIVE(a1)
    );

    uart_rx_frame #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2),
        .ACT_HOLD(50)
    ) u_n2 (
        .FPGA_CLK(clk), .FPGA_RST(rst), .UART_RXD(rxd[2]), .RX_DATA(d2), .RX_VALID(v2),
        .RX_PARITY_ERR(pe2), .RX_FRAME_ERR(fe2), .RX_BUSY(b2), .RX_ACTIVE(a2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitors.
    always @(posedge clk) begin
        if (v0) begin
            cnt0   <= cnt0 + 1;
            stamp0 <= cyc;
            q0.push_back({pe0, fe0, d0});
        end
        if (v1) cnt1 <= cnt1 + 1;
        if (v2) cnt2 <= cnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive n bits LSB first, one bit period each, starting at a falling clock edge.
    task automatic drive_bits(input int idx, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxd[idx] = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t0;
        int c;
        logic [9:0] e;

        idle(3);
        check("rst_data", 32'(d0), 32'h00);
        check("rst_valid", 32'(v0), 32'h0);
        check("rst_perr", 32'(pe0), 32'h0);
        check("rst_ferr", 32'(fe0), 32'h0);
        check("rst_busy", 32'(b0), 32'h0);
        check("rst_active", 32'(a0), 32'h0);
        rst = 1'b0;
        idle(5);
        check("idle_busy", 32'(b0), 32'h0);

        // 8N1 0xA5 with latency measurement.
        t0 = cyc;
        drive_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
        idle(20);
        check("n1_count", 32'(cnt0), 32'd1);
        check("n1_data", 32'(d0), 32'hA5);
        check("n1_perr", 32'(pe0), 32'h0);
        check("n1_ferr", 32'(fe0), 32'h0);
        check("n1_latency", 32'(stamp0 - t0), 32'd98);
        check("n1_busy", 32'(b0), 32'h0);
        idle(60);
        check("n1_act_off", 32'(a0), 32'h0);

        // Short glitch: no strobe, FSM back to idle, activity stretched.
        rxd[0] = 1'b0;
        idle(3);
        rxd[0] = 1'b1;
        idle(8);
        check("gl_busy", 32'(b0), 32'h0);
        check("gl_act_on", 32'(a0), 32'h1);
        idle(32);
        check("gl_act_hold", 32'(a0), 32'h1);
        idle(20);
        check("gl_act_off", 32'(a0), 32'h0);
        check("gl_count", 32'(cnt0), 32'd1);

        // Back-to-back frames with no idle gap.
        q0.delete();
        drive_bits(0, 16'({1'b1, 8'h55, 1'b0}), 10);
        drive_bits(0, 16'({1'b1, 8'hAA, 1'b0}), 10);
        drive_bits(0, 16'({1'b1, 8'hFF, 1'b0}), 10);
        idle(20);
        check("b2b_count", 32'(q0.size()), 32'd3);
        e = (q0.size() != 0) ? q0.pop_front() : 10'h3FF;
        check("b2b_0", 32'(e), 32'h055);
        e = (q0.size() != 0) ? q0.pop_front() : 10'h3FF;
        check("b2b_1", 32'(e), 32'h0AA);
        e = (q0.size() != 0) ? q0.pop_front() : 10'h3FF;
        check("b2b_2", 32'(e), 32'h0FF);

        // 8E1: wrong then correct parity for 0x07 (three ones, even parity bit = 1).
        drive_bits(1, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
        idle(20);
        check("e1_count_a", 32'(cnt1), 32'd1);
        check("e1_perr_a", 32'(pe1), 32'h1);
        check("e1_data_a", 32'(d1), 32'h07);
        check("e1_ferr_a", 32'(fe1), 32'h0);
        drive_bits(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        idle(20);
        check("e1_count_b", 32'(cnt1), 32'd2);
        check("e1_perr_b", 32'(pe1), 32'h0);

        // 8N2: second stop bit low, line then held low.
        drive_bits(2, 16'({1'b0, 1'b1, 8'h81, 1'b0}), 11);
        rxd[2] = 1'b0;
        idle(30);
        check("n2_count_a", 32'(cnt2), 32'd1);
        check("n2_ferr_a", 32'(fe2), 32'h1);
        check("n2_perr_a", 32'(pe2), 32'h0);
        check("n2_data_a", 32'(d2), 32'h81);
        check("n2_wait_busy", 32'(b2), 32'h1);
        rxd[2] = 1'b1;
        idle(20);
        check("n2_idle_busy", 32'(b2), 32'h0);
        check("n2_no_extra", 32'(cnt2), 32'd1);
        drive_bits(2, 16'({2'b11, 8'h3C, 1'b0}), 11);
        idle(30);
        check("n2_count_b", 32'(cnt2), 32'd2);
        check("n2_data_b", 32'(d2), 32'h3C);
        check("n2_ferr_b", 32'(fe2), 32'h0);

        // Reset mid-DATA of 0x12, then a clean 0x34.
        c = cnt0;
        drive_bits(0, 16'({1'b1, 8'h12, 1'b0}), 4);
        rxd[0] = 1'b1;
        rst = 1'b1;
        idle(2);
        check("mr_busy", 32'(b0), 32'h0);
        check("mr_data", 32'(d0), 32'h00);
        rst = 1'b0;
        idle(30);
        check("mr_no_strobe", 32'(cnt0 - c), 32'd0);
        check("mr_idle", 32'(b0), 32'h0);
        drive_bits(0, 16'({1'b1, 8'h34, 1'b0}), 10);
        idle(20);
        check("mr_count", 32'(cnt0 - c), 32'd1);
        check("mr_data_b", 32'(d0), 32'h34);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
